ex_issue_skid_buffer: RTL and testbench

- Two-entry valid/ready skid buffer between ID/EX decode and the EX-stage ALU result-select bank.
- The result-select bank is a set of 8:1 muxes driven by a 3-bit select.
- Registers the ALU select, operands and write-back control so the 3-bit select reaching the mux bank always comes from a flop.
- Decouples decode stall logic from the EX ready path, so there is no combinational ready path upstream.

---
 rtl/ex_issue_skid_buffer_pkg.sv | 24 ++
 rtl/ex_payload_reg.sv | 17 +
 rtl/ex_issue_skid_buffer.sv | 89 ++++++++
 tb/tb_ex_issue_skid_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_skid_buffer_pkg.sv
// Shared types for the EX issue skid buffer: ALU select codes, payload layout, buffer state.
package ex_pkg;
  localparam int SEL_W     = 3;
  localparam int EX_DATA_W = 64;
  localparam int EX_REG_W  = 5;

  typedef enum logic [SEL_W-1:0] {
    ADD, SUB, AND, ORR, EOR, LSL, LSR, PASSB
  } alu_sel_e;

  typedef enum logic [1:0] {
    EMPTY, BUSY, FULL
  } buf_state_e;

  // Default-width view of one issue payload; the top packs the same field order.
  typedef struct packed {
    logic [SEL_W-1:0]     alu_sel;
    logic [EX_DATA_W-1:0] op_a;
    logic [EX_DATA_W-1:0] op_b;
    logic [EX_REG_W-1:0]  rd;
    logic                 reg_write;
    logic                 mem_read;
  } ex_payload_t;
endpackage

// File: rtl/ex_payload_reg.sv
// Payload flop: async active-low reset, synchronous clear dominating load enable.
module ex_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end
endmodule

// File: rtl/ex_issue_skid_buffer.sv
// Two-entry skid buffer feeding the EX result-select bank; ready is decoded from state only.
// Optional stall counter port enabled by defining EX_STALL_CNT_EN.
module ex_issue_skid_buffer import ex_pkg::*; #(
  parameter int DATA_W = EX_DATA_W,
  parameter int REG_W  = EX_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_alu_sel,
  input  logic [DATA_W-1:0] in_op_a,
  input  logic [DATA_W-1:0] in_op_b,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_alu_sel,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam int PW = SEL_W + 2*DATA_W + REG_W + 2;

  buf_state_e state_q, state_d;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic in_fire, out_fire, main_ld, skid_ld, main_from_skid;
  logic rw_q, mr_q;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign in_pl  = {in_alu_sel, in_op_a, in_op_b, in_rd, in_reg_write, in_mem_read};
  assign main_d = main_from_skid ? skid_q : in_pl;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: if (in_fire) begin state_d = BUSY; main_ld = 1'b1; end
      BUSY: begin
        if (in_fire && out_fire) main_ld = 1'b1;
        else if (in_fire)  begin state_d = FULL; skid_ld = 1'b1; end
        else if (out_fire) state_d = EMPTY;
      end
      FULL: if (out_fire) begin state_d = BUSY; main_ld = 1'b1; main_from_skid = 1'b1; end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any transfer; the payload regs clear via their clr input.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  ex_payload_reg #(.W(PW)) u_main (
    .clk(clk), .reset(reset), .clr(flush), .ld(main_ld), .d(main_d), .q(main_q)
  );

  ex_payload_reg #(.W(PW)) u_skid (
    .clk(clk), .reset(reset), .clr(flush), .ld(skid_ld), .d(in_pl), .q(skid_q)
  );

  assign {out_alu_sel, out_op_a, out_op_b, out_rd, rw_q, mr_q} = main_q;
  assign out_reg_write = rw_q & out_valid;
  assign out_mem_read  = mr_q & out_valid;

`ifdef EX_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles <= '0;
    else if (out_valid && !out_ready && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ex_issue_skid_buffer.sv
// Directed bench for ex_issue_skid_buffer with a two-deep queue model checked every cycle.
module tb_ex_issue_skid_buffer;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_alu_sel = '0;
  logic [63:0] in_op_a = '0, in_op_b = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0, in_mem_read = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [2:0]  out_alu_sel;
  logic [63:0] out_op_a, out_op_b;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read;
`ifdef EX_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_issue_skid_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_sel(in_alu_sel), .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_sel(out_alu_sel), .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
`ifdef EX_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an order-preserving queue holding at most two payloads.
  ex_payload_t mq[$];
  longint unsigned m_stall = 0;

  function automatic ex_payload_t cur_in();
    ex_payload_t p;
    p.alu_sel = in_alu_sel; p.op_a = in_op_a; p.op_b = in_op_b;
    p.rd = in_rd; p.reg_write = in_reg_write; p.mem_read = in_mem_read;
    return p;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_stall = 0;
    end else begin
      bit acc, pop;
      acc = in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && out_ready;
      if (mq.size() > 0 && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(cur_in());
      end
    end
  end

  always @(negedge clk) begin
    bit v;
    v = (mq.size() > 0);
    chk("m_out_valid", out_valid, v);
    chk("m_in_ready", in_ready, mq.size() < 2);
    chk("m_reg_write", out_reg_write, v ? mq[0].reg_write : 1'b0);
    chk("m_mem_read", out_mem_read, v ? mq[0].mem_read : 1'b0);
    if (v) begin
      chk("m_alu_sel", out_alu_sel, mq[0].alu_sel);
      chk("m_op_a", out_op_a, mq[0].op_a);
      chk("m_op_b", out_op_b, mq[0].op_b);
      chk("m_rd", out_rd, mq[0].rd);
    end
`ifdef EX_STALL_CNT_EN
    chk("m_stall", stall_cycles, m_stall[31:0]);
`endif
  end

  task automatic set_in(input bit v, input logic [2:0] s, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] r, input bit rw, input bit mr);
    in_valid = v; in_alu_sel = s; in_op_a = a; in_op_b = b;
    in_rd = r; in_reg_write = rw; in_mem_read = mr;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held with a valid input pending
    set_in(1, 3'd5, 64'd9, 64'd9, 5'd1, 1, 1);
    step(); step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_sel", out_alu_sel, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    chk("post_rst_no_cap", out_valid, 1'b0);

    // Pass-through
    out_ready = 1'b1;
    set_in(1, 3'b010, 64'd5, 64'd7, 5'd4, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("pt_valid", out_valid, 1'b1);
    chk("pt_sel", out_alu_sel, 3'b010);
    chk("pt_op_a", out_op_a, 64'd5);
    chk("pt_op_b", out_op_b, 64'd7);
    chk("pt_rd", out_rd, 5'd4);
    chk("pt_rw", out_reg_write, 1'b1);
    for (int i = 0; i < 8; i++) begin
      set_in(1, 3'(i), 64'(i * 3), 64'(100 + i), 5'(i), i[0], i[1]);
      step();
      chk("stream_sel", out_alu_sel, 64'(i));
      chk("stream_ready", in_ready, 1'b1);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    // Bubble after a payload with mem_read=1 and reg_write=1 (sel 7)
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_rw", out_reg_write, 1'b0);
    chk("bubble_mr", out_mem_read, 1'b0);

    // Backpressure: A then B
    out_ready = 1'b0;
    set_in(1, 3'd1, 64'hA, 64'hA0, 5'd10, 1, 0); step();
    set_in(1, 3'd6, 64'hB, 64'hB0, 5'd11, 0, 1); step();
    set_in(1, 3'd4, 64'hC, 64'hC0, 5'd12, 1, 1); step();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_sel", out_alu_sel, 3'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    step();
    chk("bp_drain_b", out_alu_sel, 3'd6);
    chk("bp_ready_back", in_ready, 1'b1);
    step();
    chk("bp_empty", out_valid, 1'b0);

    // Flush while FULL with C offered
    out_ready = 1'b0;
    set_in(1, 3'd1, 64'hA, 64'hA0, 5'd10, 1, 0); step();
    set_in(1, 3'd6, 64'hB, 64'hB0, 5'd11, 1, 0); step();
    set_in(1, 3'd3, 64'hC, 64'hC0, 5'd13, 1, 1);
    flush = 1'b1;
    #2;
    chk("fl_head_visible", out_valid, 1'b1);
    step();
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_rw", out_reg_write, 1'b0);
    step();
    chk("fl_no_cap", out_valid, 1'b0);

    // Reset mid-FULL
    set_in(1, 3'd2, 64'h1, 64'h2, 5'd3, 1, 0); step();
    set_in(1, 3'd5, 64'h4, 64'h5, 5'd6, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    step();
    reset = 1'b1;
    step();

`ifdef EX_STALL_CNT_EN
    chk("stall_zero", stall_cycles, 32'd0);
    out_ready = 1'b0;
    set_in(1, 3'd7, 64'h77, 64'h78, 5'd7, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    chk("stall_ten", stall_cycles, 32'd10);
    out_ready = 1'b1;
    flush = 1'b1; step();
    flush = 1'b0;
    step();
    chk("stall_after_flush", stall_cycles, 32'd10);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
